// File: rtl/keccak_multi_clock_gate.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : keccak_multi_clock_gate
//  Purpose  : Automatic clock gating for NumCh independent Keccak clock
//             domains. Each channel stops its clock after IdleCycles
//             consecutive idle cycles. A req/ack handshake restarts the
//             clock, and ack follows a fixed WakeCycles settle time.
//             A saturating gated-cycle counter per channel feeds the power
//             monitoring CSRs.
//  Ports    : clk_i        free-running clock
//             rst_ni       synchronous active-low reset
//             test_en_i    forces every ICG enable on (scan)
//             busy_i       per-channel work in flight
//             force_en_i   per-channel software keep-alive
//             req_i        per-channel clock request
//             ack_o        per-channel clock running and settled
//             clk_o        per-channel gated clock
//             gated_o      per-channel "clock is stopped" status
//             cnt_clr_i    clear all gated-cycle counters
//             gated_cnt_o  channel c counter at [c*CntW +: CntW]
//  Revision : 1.0  initial release
// ============================================================================
module keccak_multi_clock_gate #(
    parameter int NumCh      = 4,
    parameter int IdleCycles = 8,
    parameter int WakeCycles = 2,
    parameter int CntW       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_en_i,
    input  logic [NumCh-1:0]      busy_i,
    input  logic [NumCh-1:0]      force_en_i,
    input  logic [NumCh-1:0]      req_i,
    output logic [NumCh-1:0]      ack_o,
    output logic [NumCh-1:0]      clk_o,
    output logic [NumCh-1:0]      gated_o,
    input  logic                  cnt_clr_i,
    output logic [NumCh*CntW-1:0] gated_cnt_o
);

    localparam int c_IDLE_W = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
    localparam int c_WAKE_W = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IdleCycles - 1);
    localparam logic [c_WAKE_W-1:0] c_WAKE_LAST = c_WAKE_W'(WakeCycles - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_GATED  = 2'd1,
        ST_WAKE   = 2'd2
    } state_e;

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        state_e              r_state;
        state_e              w_state_nxt;
        logic                r_en;
        logic                w_en_nxt;
        logic [c_IDLE_W-1:0] r_idle_cnt;
        logic [c_IDLE_W-1:0] w_idle_cnt_nxt;
        logic [c_WAKE_W-1:0] r_wake_cnt;
        logic [c_WAKE_W-1:0] w_wake_cnt_nxt;
        logic [CntW-1:0]     r_gcnt;
        logic                r_icg_en;
        logic                w_idle;

        assign w_idle = !busy_i[c] && !req_i[c] && !force_en_i[c];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_state    <= ST_ACTIVE;
                r_en       <= 1'b1;
                r_idle_cnt <= '0;
                r_wake_cnt <= '0;
            end else begin
                r_state    <= w_state_nxt;
                r_en       <= w_en_nxt;
                r_idle_cnt <= w_idle_cnt_nxt;
                r_wake_cnt <= w_wake_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt    = r_state;
            w_en_nxt       = r_en;
            w_idle_cnt_nxt = r_idle_cnt;
            w_wake_cnt_nxt = r_wake_cnt;
            case (r_state)
                ST_ACTIVE: begin
                    if (w_idle) begin
                        if (r_idle_cnt == c_IDLE_LAST) begin
                            w_state_nxt    = ST_GATED;
                            w_en_nxt       = 1'b0;
                            w_idle_cnt_nxt = '0;
                        end else begin
                            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                        end
                    end else begin
                        w_idle_cnt_nxt = '0;
                    end
                end
                ST_GATED: begin
                    if (!w_idle) begin
                        w_state_nxt    = ST_WAKE;
                        w_en_nxt       = 1'b1;
                        w_wake_cnt_nxt = '0;
                    end
                end
                ST_WAKE: begin
                    // Inputs are ignored here: a wake always runs to ACTIVE.
                    if (r_wake_cnt == c_WAKE_LAST) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_wake_cnt_nxt = r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACTIVE;
                    w_en_nxt    = 1'b1;
                end
            endcase
        end

        // Clear wins over increment; the count sticks at all-ones.
        always_ff @(posedge clk_i) begin
            if (!rst_ni || cnt_clr_i) begin
                r_gcnt <= '0;
            end else if ((r_state == ST_GATED) && (r_gcnt != {CntW{1'b1}})) begin
                r_gcnt <= r_gcnt + 1'b1;
            end
        end

        // Latch-based ICG: enable only changes while clk_i is low, so the
        // AND below cannot chop a high phase.
        always_latch begin
            if (!clk_i) begin
                r_icg_en <= r_en | test_en_i;
            end
        end

        assign clk_o[c]   = clk_i & r_icg_en;
        assign ack_o[c]   = rst_ni && (r_state == ST_ACTIVE) && req_i[c];
        assign gated_o[c] = (r_state == ST_GATED);
        assign gated_cnt_o[c*CntW +: CntW] = r_gcnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_multi_clock_gate.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_keccak_multi_clock_gate
//  Purpose  : Scoreboard bench for keccak_multi_clock_gate. A driver applies
//             directed and random stimulus and pushes the expected per-cycle
//             outputs from a behavioural model. A monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keccak_multi_clock_gate;

    localparam int NCH  = 4;
    localparam int IDLE = 8;
    localparam int WAKE = 2;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              test_en;
    logic              cnt_clr;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    force_en;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    clko;
    logic [NCH-1:0]    gated;
    logic [NCH*CW-1:0] gcnt;

    keccak_multi_clock_gate #(
        .NumCh      (NCH),
        .IdleCycles (IDLE),
        .WakeCycles (WAKE),
        .CntW       (CW)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_n),
        .test_en_i   (test_en),
        .busy_i      (busy),
        .force_en_i  (force_en),
        .req_i       (req),
        .ack_o       (ack),
        .clk_o       (clko),
        .gated_o     (gated),
        .cnt_clr_i   (cnt_clr),
        .gated_cnt_o (gcnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NCH-1:0]    gated;
        logic [NCH-1:0]    ack;
        logic [NCH-1:0]    clk;
        logic              clk_valid;
        logic [NCH*CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model: plain counters, not a state machine.
    bit   m_gated [NCH];
    bit   m_en    [NCH];
    int   m_idle  [NCH];
    int   m_wake  [NCH];   // edges left before the clock is considered settled
    int   m_cnt   [NCH];
    int   edges = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit idle;
        edges++;
        for (int c = 0; c < NCH; c++) begin
            idle = !busy[c] && !req[c] && !force_en[c];
            if (!rst_n) begin
                m_gated[c] = 0; m_wake[c] = 0; m_idle[c] = 0; m_en[c] = 1; m_cnt[c] = 0;
            end else begin
                if (cnt_clr) m_cnt[c] = 0;
                else if (m_gated[c] && m_cnt[c] < MAXC) m_cnt[c]++;
                if (m_gated[c]) begin
                    if (!idle) begin
                        m_gated[c] = 0; m_wake[c] = WAKE; m_en[c] = 1;
                    end
                end else if (m_wake[c] > 0) begin
                    m_wake[c]--;
                end else if (idle) begin
                    m_idle[c]++;
                    if (m_idle[c] == IDLE) begin
                        m_gated[c] = 1; m_en[c] = 0; m_idle[c] = 0;
                    end
                end else begin
                    m_idle[c] = 0;
                end
            end
        end
    endtask

    // One cycle: let the DUT sample the current inputs, advance the model,
    // apply the next inputs and queue the outputs expected for this cycle.
    task automatic step(input logic r, input logic te, input logic clr,
                        input logic [NCH-1:0] b, input logic [NCH-1:0] f,
                        input logic [NCH-1:0] q);
        exp_t e;
        @(posedge clk_i);
        #1;
        // Clock high phase after this edge reflects the enable latched in the
        // preceding low phase.
        for (int c = 0; c < NCH; c++) e.clk[c] = m_en[c] | test_en;
        model_edge();
        e.clk_valid = (edges >= 2);
        rst_n = r; test_en = te; cnt_clr = clr; busy = b; force_en = f; req = q;
        for (int c = 0; c < NCH; c++) begin
            e.gated[c] = m_gated[c];
            e.ack[c]   = rst_n && !m_gated[c] && (m_wake[c] == 0) && req[c];
            e.cnt[c*CW +: CW] = CW'(m_cnt[c]);
        end
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gated_o", 64'(gated), 64'(e.gated));
                check("ack_o", 64'(ack), 64'(e.ack));
                check("gated_cnt_o", 64'(gcnt), 64'(e.cnt));
                if (e.clk_valid) check("clk_o", 64'(clko), 64'(e.clk));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] b, f, q;
        int dens;
        logic te;
        for (int c = 0; c < NCH; c++) begin
            m_gated[c] = 0; m_en[c] = 1; m_idle[c] = 0; m_wake[c] = 0; m_cnt[c] = 0;
        end
        rst_n = 0; test_en = 0; cnt_clr = 0; busy = '0; force_en = '0; req = '0;

        // Reset, then all idle long enough to gate and saturate the counters.
        repeat (3) step(0, 0, 0, '0, '0, '0);
        repeat (28) step(1, 0, 0, '0, '0, '0);
        // Clear coincident with increment, then counting resumes.
        step(1, 0, 1, '0, '0, '0);
        repeat (3) step(1, 0, 0, '0, '0, '0);
        // Wake handshake on channel 0 only.
        repeat (5) step(1, 0, 0, '0, '0, 4'b0001);
        repeat (12) step(1, 0, 0, '0, '0, '0);
        // Threshold race: get every channel ACTIVE, 7 idle, busy on the 8th.
        repeat (3) step(1, 0, 0, '1, '0, '0);
        repeat (7) step(1, 0, 0, '0, '0, '0);
        step(1, 0, 0, '1, '0, '0);
        repeat (10) step(1, 0, 0, '0, '0, '0);
        // Test enable while gated.
        repeat (10) step(1, 1, 0, '0, '0, '0);
        // Force wakes channel 3 like a request.
        repeat (4) step(1, 0, 0, '0, 4'b1000, '0);
        repeat (10) step(1, 0, 0, '0, '0, '0);
        // Reset one cycle into a wake of channel 2, request held.
        step(1, 0, 0, '0, '0, 4'b0100);
        step(0, 0, 0, '0, '0, 4'b0100);
        repeat (3) step(1, 0, 0, '0, '0, 4'b0100);

        // Randomised blocks with varying activity density.
        for (int blk = 0; blk < 32; blk++) begin
            dens = $urandom_range(2, 40);
            te   = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 64; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    b[c] = ($urandom_range(0, dens) == 0);
                    f[c] = ($urandom_range(0, dens * 2) == 0);
                    q[c] = ($urandom_range(0, dens) == 0);
                end
                step(($urandom_range(0, 299) != 0), te,
                     ($urandom_range(0, 39) == 0), b, f, q);
            end
        end

        repeat (2) step(1, 0, 0, '0, '0, '0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_i);
        #5;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
